// File: rtl/morse_letter_buffer.sv
// Morse entry block: straight key and dot/dash buttons are assembled into a per-letter
// pattern, committed on confirm or after an idle gap, and kept in a DEPTH-letter history.
module morse_letter_buffer #(
    parameter int CODE_W      = 16,
    parameter int MAX_SYMBOLS = 4,
    parameter int DEPTH       = 5,
    parameter int CNT_W       = 24,
    parameter int MIN_TICKS   = 2,
    parameter int DASH_TICKS  = 250000,
    parameter int GAP_TICKS   = 500000
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               key,
    input  logic                               dot_btn,
    input  logic                               dash_btn,
    input  logic                               confirm,
    input  logic                               backspace,
    output logic [DEPTH*CODE_W-1:0]            letters,
    output logic [$clog2(DEPTH+1)-1:0]         letter_cnt,
    output logic [CODE_W-1:0]                  cur_code,
    output logic [$clog2(MAX_SYMBOLS+1)-1:0]   cur_len,
    output logic                               sym_ovf,
    output logic                               key_led
);

    localparam int LEN_W = $clog2(MAX_SYMBOLS + 1);
    localparam int LC_W  = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] MIN_T    = CNT_W'(MIN_TICKS);
    localparam logic [CNT_W-1:0] DASH_T   = CNT_W'(DASH_TICKS);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_SYMBOLS);
    localparam logic [LC_W-1:0]  CNT_MAX  = LC_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] timer, timer_next;

    // Bit order: {backspace, confirm, dash_btn, dot_btn, key}
    logic [4:0] sync1, sync2, prev;
    logic [4:0] fall;
    logic       key_rise;

    logic key_sym, key_is_dash, gap_timeout;
    logic btn_sym, btn_dash, btn_act;
    logic ev_confirm, ev_bs, ev_timeout, ev_sym, sym_dash, commit;
    logic [DEPTH*CODE_W-1:0] code_ext;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {backspace, confirm, dash_btn, dot_btn, key};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign fall     = prev & ~sync2;
    assign key_rise = sync2[0] & ~prev[0];
    assign key_led  = prev[0];

    // Event arbitration: confirm > backspace > gap timeout > symbol, one symbol per cycle.
    always_comb begin
        key_sym     = (state == PRESS) && fall[0] && (timer >= MIN_T);
        key_is_dash = (timer >= DASH_T);
        gap_timeout = (state == GAP) && !key_rise && (timer == GAP_LAST);
        btn_sym     = fall[1] | fall[2];
        btn_dash    = fall[2] & ~fall[1];

        ev_confirm  = fall[3];
        ev_bs       = fall[4] & ~fall[3];
        ev_timeout  = gap_timeout & ~fall[3] & ~fall[4];
        ev_sym      = (key_sym | btn_sym) & ~fall[3] & ~fall[4] & ~gap_timeout;
        sym_dash    = key_sym ? key_is_dash : btn_dash;
        btn_act     = ev_sym & btn_sym & ~key_sym;
        commit      = ev_confirm | ev_timeout;

        code_ext                = '0;
        code_ext[CODE_W-1:0]    = cur_code;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            IDLE: begin
                if (key_rise) begin
                    state_next = PRESS;
                    timer_next = '0;
                end else if (btn_act) begin
                    state_next = GAP;
                    timer_next = '0;
                end
            end
            PRESS: begin
                if (fall[0]) begin
                    timer_next = '0;
                    if (timer < MIN_T && cur_len == '0)
                        state_next = IDLE;
                    else
                        state_next = GAP;
                end else if (timer != '1) begin
                    timer_next = timer + CNT_W'(1);
                end
            end
            GAP: begin
                if (key_rise) begin
                    state_next = PRESS;
                    timer_next = '0;
                end else if (gap_timeout) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (btn_act) begin
                    timer_next = '0;
                end else begin
                    timer_next = timer + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            letters    <= '0;
            letter_cnt <= '0;
            cur_code   <= '0;
            cur_len    <= '0;
            sym_ovf    <= 1'b0;
        end else if (commit) begin
            if (cur_len != '0) begin
                letters  <= (letters << CODE_W) | code_ext;
                if (letter_cnt != CNT_MAX)
                    letter_cnt <= letter_cnt + LC_W'(1);
                cur_code <= '0;
                cur_len  <= '0;
                sym_ovf  <= 1'b0;
            end
        end else if (ev_bs) begin
            if (cur_len != '0) begin
                cur_code <= '0;
                cur_len  <= '0;
                sym_ovf  <= 1'b0;
            end else if (letter_cnt != '0) begin
                letters    <= letters >> CODE_W;
                letter_cnt <= letter_cnt - LC_W'(1);
            end
        end else if (ev_sym) begin
            // A full letter keeps its pattern; the rejected symbol only raises the sticky flag.
            if (cur_len == LEN_MAX) begin
                sym_ovf <= 1'b1;
            end else begin
                if (sym_dash)
                    cur_code <= {cur_code[CODE_W-5:0], 4'b1110};
                else
                    cur_code <= {cur_code[CODE_W-3:0], 2'b10};
                cur_len <= cur_len + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_morse_letter_buffer.sv
// Directed bench for morse_letter_buffer: an operation-level model pushes expected
// snapshots to a scoreboard queue, popped and compared once the DUT has settled.
module tb_morse_letter_buffer;

    localparam int CODE_W = 16;
    localparam int DEPTH  = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic key = 1'b0, dot_btn = 1'b0, dash_btn = 1'b0, confirm = 1'b0, backspace = 1'b0;
    logic [DEPTH*CODE_W-1:0] letters;
    logic [1:0]  letter_cnt;
    logic [15:0] cur_code;
    logic [2:0]  cur_len;
    logic        sym_ovf;
    logic        key_led;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [47:0] letters;
        logic [1:0]  cnt;
        logic [15:0] code;
        logic [2:0]  len;
        logic        ovf;
        logic        led;
    } snap_t;

    snap_t sb[$];

    logic [15:0] m_slot [DEPTH];
    logic [1:0]  m_cnt;
    logic [15:0] m_code;
    logic [2:0]  m_len;
    logic        m_ovf;

    morse_letter_buffer #(
        .CODE_W(16), .MAX_SYMBOLS(4), .DEPTH(3), .CNT_W(8),
        .MIN_TICKS(2), .DASH_TICKS(8), .GAP_TICKS(20)
    ) dut (
        .clock(clock), .reset(reset), .key(key), .dot_btn(dot_btn),
        .dash_btn(dash_btn), .confirm(confirm), .backspace(backspace),
        .letters(letters), .letter_cnt(letter_cnt), .cur_code(cur_code),
        .cur_len(cur_len), .sym_ovf(sym_ovf), .key_led(key_led)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task m_reset();
        for (int i = 0; i < DEPTH; i++) m_slot[i] = '0;
        m_cnt = '0; m_code = '0; m_len = '0; m_ovf = 1'b0;
    endtask

    task m_symbol(input bit dash);
        if (m_len == 3'd4) m_ovf = 1'b1;
        else begin
            m_code = dash ? ((m_code << 4) | 16'hE) : ((m_code << 2) | 16'h2);
            m_len  = m_len + 3'd1;
        end
    endtask

    task m_commit();
        if (m_len != 0) begin
            for (int i = DEPTH - 1; i > 0; i--) m_slot[i] = m_slot[i-1];
            m_slot[0] = m_code;
            if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
            m_code = '0; m_len = '0; m_ovf = 1'b0;
        end
    endtask

    task m_backspace();
        if (m_len != 0) begin
            m_code = '0; m_len = '0; m_ovf = 1'b0;
        end else if (m_cnt != 0) begin
            for (int i = 0; i < DEPTH - 1; i++) m_slot[i] = m_slot[i+1];
            m_slot[DEPTH-1] = '0;
            m_cnt = m_cnt - 2'd1;
        end
    endtask

    task push_expected(input bit led);
        snap_t s;
        s.letters = {m_slot[2], m_slot[1], m_slot[0]};
        s.cnt  = m_cnt;
        s.code = m_code;
        s.len  = m_len;
        s.ovf  = m_ovf;
        s.led  = led;
        sb.push_back(s);
    endtask

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        snap_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            cmp({tag, ".letters"},    64'(letters),    64'(e.letters));
            cmp({tag, ".letter_cnt"}, 64'(letter_cnt), 64'(e.cnt));
            cmp({tag, ".cur_code"},   64'(cur_code),   64'(e.code));
            cmp({tag, ".cur_len"},    64'(cur_len),    64'(e.len));
            cmp({tag, ".sym_ovf"},    64'(sym_ovf),    64'(e.ovf));
            cmp({tag, ".key_led"},    64'(key_led),    64'(e.led));
        end
    endtask

    // Press and release a set of buttons; action lands three edges after release.
    task automatic apply_stimulus(input bit d, input bit da, input bit c, input bit b);
        dot_btn = d; dash_btn = da; confirm = c; backspace = b;
        tick(2);
        dot_btn = 1'b0; dash_btn = 1'b0; confirm = 1'b0; backspace = 1'b0;
        tick(3);
    endtask

    task automatic key_hold(input int n);
        key = 1'b1;
        tick(n);
        key = 1'b0;
        tick(3);
    endtask

    initial begin
        m_reset();
        tick(3);
        push_expected(0); check_output("reset");
        reset = 1'b1;
        tick(2);

        // Key: dot then dash, then auto-commit after the idle gap
        key_hold(4);  m_symbol(0); push_expected(0); check_output("key_dot");
        key_hold(10); m_symbol(1); push_expected(0); check_output("key_dash");
        tick(17);     push_expected(0); check_output("gap_pending");
        tick(5);      m_commit(); push_expected(0); check_output("gap_commit");

        // Dot button overflow and confirm
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 0, 0, 0); m_symbol(0);
        end
        push_expected(0); check_output("four_dots");
        apply_stimulus(1, 0, 0, 0); m_symbol(0); push_expected(0); check_output("dot_ovf");
        apply_stimulus(0, 0, 1, 0); m_commit(); push_expected(0); check_output("confirm_ovf");

        // History fill and saturation
        apply_stimulus(1, 0, 0, 0); m_symbol(0);
        apply_stimulus(0, 0, 1, 0); m_commit(); push_expected(0); check_output("commit_dot");
        apply_stimulus(0, 1, 0, 0); m_symbol(1);
        apply_stimulus(0, 0, 1, 0); m_commit(); push_expected(0); check_output("commit_sat");
        apply_stimulus(1, 0, 0, 0); m_symbol(0);
        apply_stimulus(1, 0, 0, 0); m_symbol(0);
        apply_stimulus(0, 0, 1, 0); m_commit();
        apply_stimulus(0, 1, 0, 0); m_symbol(1);
        apply_stimulus(0, 1, 0, 0); m_symbol(1);
        apply_stimulus(0, 0, 1, 0); m_commit(); push_expected(0); check_output("history_full");

        // Simultaneous dot and dash gives a dot; backspace clears the partial letter
        apply_stimulus(1, 1, 0, 0); m_symbol(0); push_expected(0); check_output("dot_dash_same");
        apply_stimulus(0, 0, 0, 1); m_backspace(); push_expected(0); check_output("bs_partial");

        // Backspace walks the history down to empty, then is a no-op
        apply_stimulus(0, 0, 0, 1); m_backspace(); push_expected(0); check_output("bs_hist2");
        apply_stimulus(0, 0, 0, 1); m_backspace(); push_expected(0); check_output("bs_hist1");
        apply_stimulus(0, 0, 0, 1); m_backspace(); push_expected(0); check_output("bs_hist0");
        apply_stimulus(0, 0, 0, 1); m_backspace(); push_expected(0); check_output("bs_empty");

        // Glitch key pulse, then confirm beats a simultaneous dash
        apply_stimulus(1, 0, 0, 0); m_symbol(0); push_expected(0); check_output("pre_glitch");
        key_hold(1); push_expected(0); check_output("key_glitch");
        apply_stimulus(0, 1, 1, 0); m_commit(); push_expected(0); check_output("confirm_vs_dash");
        apply_stimulus(0, 0, 1, 0); m_commit(); push_expected(0); check_output("confirm_empty");

        // Reset in the middle of a key press discards everything
        apply_stimulus(1, 0, 0, 0); m_symbol(0);
        apply_stimulus(1, 0, 0, 0); m_symbol(0); push_expected(0); check_output("pre_reset");
        key = 1'b1;
        tick(5);      push_expected(1); check_output("key_led_on");
        reset = 1'b0;
        tick(1);      m_reset(); push_expected(0); check_output("reset_mid_press");
        key = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(10);     push_expected(0); check_output("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
